// File: rtl/param_grf.sv
// Multi-port register file with per-register busy scoreboard and write-to-read bypass.
// Latency: reads are combinational (zero cycles); writes, allocs and flush take effect at the next rising clk.
// Backpressure: none; every port is accepted every cycle, and rd_busy tells the consumer to wait.
module param_grf #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  input  logic                     flush
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  // True when the address is the hardwired-zero register.
  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Register write: ports applied in ascending order so the highest-numbered port wins a collision.
  always_comb begin
    regs_d = regs_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w] && !is_zero(wr_addr[w*ADDR_W +: ADDR_W])) begin
        regs_d[wr_addr[w*ADDR_W +: ADDR_W]] = wr_data[w*DATA_W +: DATA_W];
      end
    end
  end

  // Busy update priority: write clears, then alloc sets (newer producer), then flush clears everything.
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w]) begin
        busy_d[wr_addr[w*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (alloc_en) begin
      busy_d[alloc_addr] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
    if (ZERO_REG != 0) begin
      busy_d[0] = 1'b0;
    end
  end

  // State registers; reset clears data and scoreboard immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int a = 0; a < DEPTH; a++) begin
        regs_q[a] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Read ports with same-cycle bypass; a bypassed value is final unless re-allocated this cycle.
  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] d;
    logic              b;
    logic              hit;
    rd_data = '0;
    rd_busy = '0;
    ra  = '0;
    d   = '0;
    b   = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra  = rd_addr[k*ADDR_W +: ADDR_W];
      d   = regs_q[ra];
      b   = busy_q[ra];
      hit = 1'b0;
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == ra)) begin
          d   = wr_data[w*DATA_W +: DATA_W];
          hit = 1'b1;
        end
      end
      if (hit && !(alloc_en && (alloc_addr == ra))) begin
        b = 1'b0;
      end
      if (!reset || is_zero(ra)) begin
        d = '0;
        b = 1'b0;
      end
      rd_data[k*DATA_W +: DATA_W] = d;
      rd_busy[k]                  = b;
    end
  end

endmodule
